seg7_scan_ctrl: RTL and testbench
=================================

# seg7_scan_ctrl

Parametrised multi-digit hexadecimal 7-segment display controller, successor to the single-digit combinational hex decoder. Latches an NDIG-digit value with per-digit decimal-point, blank and blink masks on a load strobe. Drives both a static per-digit segment bus (DE-board style dedicated HEX pins) and a time-multiplexed scanned bus (shared segment lines plus active-low digit enables). Sits between core status/debug registers and the board display pins.

## Interface
- NDIG, 4: number of digits, legal range 1..8.
- SCAN_DIV, 1024: clock cycles per scanned digit slot, ≥2.
- BLINK_DIV, 2^22: clock cycles per blink half-period, ≥2.
- p_reset  in  1  synchronous active-high reset.
- m_clock  in  1  the single clock; all state is on its rising edge.
- load  in  1  latches iVAL/iDP/iBLANK/iBLINK into shadow registers.
- iVAL  in  4*NDIG  digit values, digit d = iVAL[4d+3:4d], digit 0 = least significant.
- iDP  in  NDIG  decimal point on, per digit (active high).
- iBLANK  in  NDIG  force digit dark: segments and DP.
- iBLINK  in  NDIG  digit blinks.
- lz_en  in  1  leading-zero suppression enable, live (not latched).
- oHEX  out  7*NDIG  static segments, digit d = oHEX[7d+6:7d], active low.
- oSEG  out  7  scanned segments, active low.
- oDP  out  1  scanned decimal point, active low.
- oAN  out  NDIG  scanned digit enables, active low, at most one low.

## Operation
- Segment bit i = segment a..g for i = 0..6; 0 = lit.
- Decode, value → {g..a}:
  - 0:1000000, 1:1111001, 2:0100100, 3:0110000
  - 4:0011001, 5:0010010, 6:0000010, 7:1111000
  - 8:0000000, 9:0010000, A:0001000, b:0000011
  - C:1000110, d:0100001, E:0000110, F:0001110
  - dark = 1111111.
- Shadow registers: val, dp, blank, blink. Loaded on any cycle with load=1. The whole word is updated atomically, so there is no tearing mid-scan.
- Leading-zero suppression (lz_en=1):
  - Digit d is suppressed iff d>0 and val digits NDIG-1..d are all zero.
  - Digit 0 is never suppressed.
  - DP of a suppressed digit still follows dp.
- Blink:
  - blink_cnt counts 0..BLINK_DIV-1; phase toggles at terminal count.
  - While phase=1, digits with blink bit set are dark, including DP.
- Effective digit is dark if blank, blink-dark or suppressed; otherwise the decoded value. DP is lit iff dp=1 and neither blank nor blink-dark.
- Scan:
  - scan_cnt counts 0..SCAN_DIV-1.
  - At terminal count, idx advances (NDIG-1 wraps to 0).
  - Each slot of SCAN_DIV cycles starts with one dead cycle (oAN all ones, anti-ghosting). The remaining SCAN_DIV-1 cycles have oAN[idx]=0 with oSEG/oDP = effective digit idx.
  - NDIG=1: oAN[0] is low except in dead cycles.
- Reset values:
  - val=0, dp=0, blank=all ones, blink=0.
  - scan_cnt=0, idx=0, blink_cnt=0, phase=0.
  - oHEX all ones, oSEG=7'h7F, oDP=1, oAN all ones.

## Timing
- All outputs are registered.
- Load latency: load=1 sampled at edge k → shadow updated at k → oHEX reflects new data after edge k+1. Scanned outputs use the new data from edge k+1 whenever that digit is selected.
- lz_en changes appear on outputs one edge after they are sampled.
- Scan outputs lag the counters by one cycle. After reset release:
  - 1st edge: dead cycle.
  - 2nd edge: oAN[0]=0, held SCAN_DIV-1 cycles.
  - Then 1 dead cycle, then oAN[1]=0, and so on. Full frame = NDIG*SCAN_DIV cycles.
- Blink: the phase is 0 for the first BLINK_DIV cycles after reset, then alternates every BLINK_DIV cycles.
- Reset mid-operation: on the next edge all outputs and state return to reset values. Scanning restarts at digit 0 with a dead cycle.
- load and p_reset in the same cycle: reset wins; load is ignored.
- load held high: shadow tracks the inputs every cycle.

## Test plan
Bench parameters: NDIG=4, SCAN_DIV=4, BLINK_DIV=16.

1. Reset, then load iVAL=16'h1234, iBLANK=0, iDP=4'b0100, lz_en=0.
   - Before load: oHEX=28'hFFFFFFF.
   - One edge after the shadow update: digit3=1111001, digit2=0100100, digit1=0110000, digit0=0011001.
2. Scan order with the same data.
   - oAN sequence per cycle: 1111, 1110×3, 1111, 1101×3, 1111, 1011×3, 1111, 0111×3, then repeat.
   - During oAN=1110: oSEG=0011001, oDP=1.
   - During oAN=1011: oDP=0.
3. Leading-zero suppression, lz_en=1.
   - iVAL=16'h0070: digits 3,2 = 1111111, digit1=1111000, digit0=1000000.
   - iVAL=16'h0000: only digit0 lit (1000000).
   - lz_en=0: all four show 1000000.
4. Blink: iBLINK=4'b0001, iVAL=16'h000F, iDP=4'b0001.
   - Digit0 alternates 0001110/DP lit and dark/DP dark every 16 cycles, phase 0 first.
   - Digits 1–3 are steady.
5. Decode sweep and blank.
   - Load digit0 with each value 0..F: oHEX[6:0] matches the decode table.
   - iBLANK=4'b1010: digits 3 and 1 are dark in oHEX, and oSEG=7F during their scan slots.
6. Mid-operation events.
   - Assert p_reset for 1 cycle during the oAN=1011 slot: next edge all outputs are at reset values. Scan restarts with a dead cycle, then 1110.
   - load and p_reset asserted together: shadow stays reset (blank all ones).

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - multi-digit hex 7-segment controller with static and scanned outputs
// Shadow-latched digit data, leading-zero suppression, blink and anti-ghost digit scanning.
module seg7_scan_ctrl #(
  parameter int NDIG      = 4,
  parameter int SCAN_DIV  = 1024,
  parameter int BLINK_DIV = 1 << 22
) (
  input  logic                m_clock,
  input  logic                p_reset,
  input  logic                load,
  input  logic [4*NDIG-1:0]   iVAL,
  input  logic [NDIG-1:0]     iDP,
  input  logic [NDIG-1:0]     iBLANK,
  input  logic [NDIG-1:0]     iBLINK,
  input  logic                lz_en,
  output logic [7*NDIG-1:0]   oHEX,
  output logic [6:0]          oSEG,
  output logic                oDP,
  output logic [NDIG-1:0]     oAN
);

  localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  function automatic logic [6:0] hex_decode(input logic [3:0] v);
    case (v)
      4'h0: hex_decode = 7'b1000000;
      4'h1: hex_decode = 7'b1111001;
      4'h2: hex_decode = 7'b0100100;
      4'h3: hex_decode = 7'b0110000;
      4'h4: hex_decode = 7'b0011001;
      4'h5: hex_decode = 7'b0010010;
      4'h6: hex_decode = 7'b0000010;
      4'h7: hex_decode = 7'b1111000;
      4'h8: hex_decode = 7'b0000000;
      4'h9: hex_decode = 7'b0010000;
      4'hA: hex_decode = 7'b0001000;
      4'hB: hex_decode = 7'b0000011;
      4'hC: hex_decode = 7'b1000110;
      4'hD: hex_decode = 7'b0100001;
      4'hE: hex_decode = 7'b0000110;
      default: hex_decode = 7'b0001110;
    endcase
  endfunction

  logic [4*NDIG-1:0] val_q, val_d;
  logic [NDIG-1:0]   dp_q, dp_d, blank_q, blank_d, blink_q, blink_d;
  logic [SW-1:0]     scan_cnt_q, scan_cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [BW-1:0]     blink_cnt_q, blink_cnt_d;
  logic              phase_q, phase_d;
  logic [7*NDIG-1:0] hex_q, hex_d;
  logic [6:0]        seg_q, seg_d;
  logic              sdp_q, sdp_d;
  logic [NDIG-1:0]   an_q, an_d;

  logic [6:0]        seg_eff [NDIG];
  logic [NDIG-1:0]   dp_lit;
  logic              upper_zero, blink_dark, dark;

  always_comb begin
    val_d   = val_q;
    dp_d    = dp_q;
    blank_d = blank_q;
    blink_d = blink_q;
    if (load) begin
      val_d   = iVAL;
      dp_d    = iDP;
      blank_d = iBLANK;
      blink_d = iBLINK;
    end

    scan_cnt_d = scan_cnt_q + SW'(1);
    idx_d      = idx_q;
    if (scan_cnt_q == SW'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      idx_d      = (idx_q == IW'(NDIG - 1)) ? '0 : idx_q + IW'(1);
    end

    blink_cnt_d = blink_cnt_q + BW'(1);
    phase_d     = phase_q;
    if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end

    // Walk from the most significant digit so upper_zero covers digits NDIG-1..d.
    upper_zero = 1'b1;
    blink_dark = 1'b0;
    dark       = 1'b0;
    hex_d      = '1;
    dp_lit     = '0;
    for (int d = NDIG - 1; d >= 0; d--) begin
      upper_zero  = upper_zero & (val_q[4*d +: 4] == 4'h0);
      blink_dark  = phase_q & blink_q[d];
      dark        = blank_q[d] | blink_dark | (lz_en & upper_zero & (d != 0));
      seg_eff[d]  = dark ? 7'h7F : hex_decode(val_q[4*d +: 4]);
      dp_lit[d]   = dp_q[d] & ~blank_q[d] & ~blink_dark;
      hex_d[7*d +: 7] = seg_eff[d];
    end

    // First cycle of every slot is dead so the previous digit never ghosts.
    an_d  = '1;
    seg_d = 7'h7F;
    sdp_d = 1'b1;
    if (scan_cnt_q != '0) begin
      for (int d = 0; d < NDIG; d++) begin
        if (idx_q == IW'(d)) begin
          an_d[d] = 1'b0;
          seg_d   = seg_eff[d];
          sdp_d   = ~dp_lit[d];
        end
      end
    end
  end

  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      val_q       <= '0;
      dp_q        <= '0;
      blank_q     <= '1;
      blink_q     <= '0;
      scan_cnt_q  <= '0;
      idx_q       <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      hex_q       <= '1;
      seg_q       <= 7'h7F;
      sdp_q       <= 1'b1;
      an_q        <= '1;
    end else begin
      val_q       <= val_d;
      dp_q        <= dp_d;
      blank_q     <= blank_d;
      blink_q     <= blink_d;
      scan_cnt_q  <= scan_cnt_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      hex_q       <= hex_d;
      seg_q       <= seg_d;
      sdp_q       <= sdp_d;
      an_q        <= an_d;
    end
  end

  assign oHEX = hex_q;
  assign oSEG = seg_q;
  assign oDP  = sdp_q;
  assign oAN  = an_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - self-checking bench for seg7_scan_ctrl
// Cycle model derives outputs from edge count since reset and the latched shadow words.
module tb_seg7_scan_ctrl;
  localparam int NDIG = 4, SCAN_DIV = 4, BLINK_DIV = 16;
  localparam int FRAME = NDIG * SCAN_DIV;

  logic        m_clock = 1'b0;
  logic        p_reset = 1'b1;
  logic        load = 1'b0;
  logic        lz_en = 1'b0;
  logic [15:0] iVAL = '0;
  logic [3:0]  iDP = '0, iBLANK = '0, iBLINK = '0;
  logic [27:0] oHEX;
  logic [6:0]  oSEG;
  logic        oDP;
  logic [3:0]  oAN;

  seg7_scan_ctrl #(.NDIG(NDIG), .SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
    .m_clock(m_clock), .p_reset(p_reset), .load(load), .iVAL(iVAL), .iDP(iDP),
    .iBLANK(iBLANK), .iBLINK(iBLINK), .lz_en(lz_en),
    .oHEX(oHEX), .oSEG(oSEG), .oDP(oDP), .oAN(oAN)
  );

  always #5 m_clock = ~m_clock;

  int total = 0;
  int bad = 0;

  logic [6:0] dec [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic [15:0] m_val;
  logic [3:0]  m_dp, m_blank, m_blink;
  int          n;
  logic [27:0] e_hex;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic [3:0]  e_an;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns {dp_n, seg} for digit d as the display should show it.
  function automatic logic [7:0] model_digit(input int d, input logic ph, input logic lz);
    logic bd, sup;
    logic [3:0] v;
    logic [6:0] s;
    logic dpn;
    bd  = ph && m_blink[d];
    sup = lz && (d > 0) && ((m_val >> (4 * d)) == 16'h0);
    v   = m_val[4*d +: 4];
    s   = (m_blank[d] || bd || sup) ? 7'h7F : dec[v];
    dpn = !(m_dp[d] && !m_blank[d] && !bd);
    return {dpn, s};
  endfunction

  task automatic step();
    logic ph;
    logic [7:0] t;
    logic [3:0] one;
    int c;
    one = 4'b0001;
    if (p_reset) begin
      m_val = '0; m_dp = '0; m_blank = '1; m_blink = '0; n = 0;
      e_hex = '1; e_seg = 7'h7F; e_dp = 1'b1; e_an = '1;
    end else begin
      ph = ((n / BLINK_DIV) % 2) == 1;
      for (int d = 0; d < NDIG; d++) begin
        t = model_digit(d, ph, lz_en);
        e_hex[7*d +: 7] = t[6:0];
      end
      c = n % FRAME;
      if (c % SCAN_DIV == 0) begin
        e_seg = 7'h7F; e_dp = 1'b1; e_an = '1;
      end else begin
        t = model_digit(c / SCAN_DIV, ph, lz_en);
        e_seg = t[6:0]; e_dp = t[7];
        e_an = ~(one << (c / SCAN_DIV));
      end
      if (load) begin
        m_val = iVAL; m_dp = iDP; m_blank = iBLANK; m_blink = iBLINK;
      end
      n++;
    end
    @(posedge m_clock);
    #1;
    chk("oHEX", {4'h0, oHEX}, {4'h0, e_hex});
    chk("oSEG", {25'h0, oSEG}, {25'h0, e_seg});
    chk("oDP", {31'h0, oDP}, {31'h0, e_dp});
    chk("oAN", {28'h0, oAN}, {28'h0, e_an});
  endtask

  task automatic seek_an(input logic [3:0] want);
    for (int i = 0; i < 2 * FRAME && oAN !== want; i++) step();
    chk("seek_an", {28'h0, oAN}, {28'h0, want});
  endtask

  initial begin
    // 1: reset and first load
    p_reset = 1'b1; step(); step();
    p_reset = 1'b0; step();
    chk("pre_load_hex", {4'h0, oHEX}, 32'h0FFFFFFF);
    iVAL = 16'h1234; iDP = 4'b0100; iBLANK = 4'b0000; iBLINK = 4'b0000; lz_en = 1'b0;
    load = 1'b1; step();
    load = 1'b0; step();
    chk("load_1234", {4'h0, oHEX}, {4'h0, 7'h79, 7'h24, 7'h30, 7'h19});

    // 2: scan order
    for (int i = 0; i < 2 * FRAME; i++) step();
    seek_an(4'b1110);
    chk("scan0_seg", {25'h0, oSEG}, 32'h19);
    chk("scan0_dp", {31'h0, oDP}, 32'h1);
    seek_an(4'b1011);
    chk("scan2_dp", {31'h0, oDP}, 32'h0);

    // 3: leading-zero suppression
    iVAL = 16'h0070; lz_en = 1'b1; load = 1'b1; step();
    load = 1'b0; step();
    chk("lz_0070", {4'h0, oHEX}, {4'h0, 7'h7F, 7'h7F, 7'h78, 7'h40});
    iVAL = 16'h0000; load = 1'b1; step();
    load = 1'b0; step();
    chk("lz_0000", {4'h0, oHEX}, {4'h0, 7'h7F, 7'h7F, 7'h7F, 7'h40});
    for (int i = 0; i < FRAME; i++) step();
    lz_en = 1'b0; step();
    chk("lz_off", {4'h0, oHEX}, {4'h0, 7'h40, 7'h40, 7'h40, 7'h40});

    // 4: blink
    iBLINK = 4'b0001; iVAL = 16'h000F; iDP = 4'b0001; load = 1'b1; step();
    load = 1'b0;
    for (int i = 0; i < 4 * BLINK_DIV; i++) step();

    // 5: decode sweep and blank
    iBLINK = 4'b0000; iDP = 4'b0000;
    for (int v = 0; v < 16; v++) begin
      iVAL = 16'(v); load = 1'b1; step();
      load = 1'b0; step();
      chk("decode", {25'h0, oHEX[6:0]}, {25'h0, dec[v]});
    end
    iBLANK = 4'b1010; load = 1'b1; step();
    load = 1'b0; step();
    chk("blank_d3", {25'h0, oHEX[27:21]}, 32'h7F);
    chk("blank_d1", {25'h0, oHEX[13:7]}, 32'h7F);
    for (int i = 0; i < FRAME; i++) step();

    // 6: mid-operation reset, then reset together with load
    iBLANK = 4'b0000; iVAL = 16'h1234; load = 1'b1; step();
    load = 1'b0;
    seek_an(4'b1011);
    p_reset = 1'b1; step();
    chk("rst_an", {28'h0, oAN}, 32'hF);
    chk("rst_hex", {4'h0, oHEX}, 32'h0FFFFFFF);
    p_reset = 1'b0; step();
    chk("restart_dead", {28'h0, oAN}, 32'hF);
    step();
    chk("restart_an0", {28'h0, oAN}, 32'hE);
    iVAL = 16'h5678; iBLANK = 4'b0000; load = 1'b1; p_reset = 1'b1; step();
    load = 1'b0; p_reset = 1'b0; step(); step();
    chk("load_rst_blank", {4'h0, oHEX}, 32'h0FFFFFFF);

    // Randomised traffic against the model
    for (int i = 0; i < 600; i++) begin
      load    = ($urandom_range(0, 3) == 0);
      iVAL    = 16'($urandom);
      iDP     = 4'($urandom);
      iBLANK  = 4'($urandom) & 4'($urandom);
      iBLINK  = 4'($urandom);
      if ($urandom_range(0, 15) == 0) lz_en = ~lz_en;
      if ($urandom_range(0, 1) == 0) iVAL = iVAL & 16'h00FF;
      p_reset = ($urandom_range(0, 99) == 0);
      step();
    end
    p_reset = 1'b0; load = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
